// File: rtl/t64_pkg.sv
`default_nettype none
// ============================================================================
// Module  : t64_pkg
// Purpose : Shared definitions for the t64 bit-serial counter sequencer:
//           the sequencer state encoding and the default bit-address width.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package t64_pkg;

    // Default bit-address width of the attached memory (depth = 2**6 = 64 bits).
    localparam int c_ADDR_W_DEFAULT = 6;

    // Sequencer states; the explicit 2-bit encoding is fixed here so that all
    // users of the package agree on it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INC  = 2'd1,
        ST_DEC  = 2'd2,
        ST_CLR  = 2'd3
    } t64_state_e;

endpackage : t64_pkg
`default_nettype wire

// File: rtl/t64_seq.sv
`default_nettype none
// ============================================================================
// Module  : t64_seq
// Purpose : Bit-serial sequencer that increments, decrements or clears a
//           2**ADDR_W-bit binary value held in an external single-bit-wide
//           memory (the t64 memory, instantiated as a sibling).
//           INC/DEC walk from the LSB upward and stop as soon as the carry /
//           borrow is absorbed; CLR walks every bit.
// Ports   :
//   c     in   clock, all state updates on the rising edge
//   r     in   synchronous active-high reset of this sequencer only
//   inc   in   request: value + 1
//   dec   in   request: value - 1
//   clr   in   request: write 0 to every memory bit
//   busy  out  high while an operation is in progress
//   done  out  registered one-cycle pulse after the final write edge
//   ovf   out  registered pulse with done on carry-out / borrow-past-MSB
//   m_s   out  [ADDR_W] bit select to the memory (bit 0 = LSB)
//   m_ce  out  memory write enable
//   m_r   out  memory per-bit clear (writes 0 at m_s)
//   m_d   out  memory write data
//   m_q   in   memory read data, combinational from m_s
// Revision: 1.0 - initial release
// ============================================================================
module t64_seq
    import t64_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEFAULT
) (
    input  logic              c,
    input  logic              r,
    input  logic              inc,
    input  logic              dec,
    input  logic              clr,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [ADDR_W-1:0] m_s,
    output logic              m_ce,
    output logic              m_r,
    output logic              m_d,
    input  logic              m_q
);

    localparam logic [ADDR_W-1:0] c_IDX_MAX  = '1;
    localparam logic [ADDR_W-1:0] c_IDX_ZERO = '0;
    localparam logic [ADDR_W-1:0] c_IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    t64_state_e        r_state;
    t64_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_ovf;
    logic              w_ovf_nxt;
    logic              w_ce;
    logic              w_clr;
    logic              w_d;
    logic              w_idx_last;

    assign w_idx_last = (r_idx == c_IDX_MAX);

    // ------------------------------------------------------------------
    // State, index and completion-flag registers
    // ------------------------------------------------------------------
    always_ff @(posedge c) begin
        if (r) begin
            r_state <= ST_IDLE;
            r_idx   <= c_IDX_ZERO;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and memory-control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        w_ovf_nxt   = 1'b0;
        w_ce        = 1'b0;
        w_clr       = 1'b0;
        w_d         = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                // Requests are only looked at here, so anything raised while
                // busy is simply dropped. clr wins over inc, inc over dec.
                w_idx_nxt = c_IDX_ZERO;
                if (clr) begin
                    w_state_nxt = ST_CLR;
                end else if (inc) begin
                    w_state_nxt = ST_INC;
                end else if (dec) begin
                    w_state_nxt = ST_DEC;
                end
            end

            ST_INC: begin
                // Adding one flips the selected bit; a 0 bit absorbs the carry.
                w_ce = 1'b1;
                w_d  = ~m_q;
                if (!m_q) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (w_idx_last) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                    w_ovf_nxt   = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + c_IDX_ONE;
                end
            end

            ST_DEC: begin
                // Subtracting one flips the selected bit; a 1 bit absorbs the borrow.
                w_ce = 1'b1;
                w_d  = ~m_q;
                if (m_q) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (w_idx_last) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                    w_ovf_nxt   = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + c_IDX_ONE;
                end
            end

            ST_CLR: begin
                w_clr = 1'b1;
                if (w_idx_last) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + c_IDX_ONE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Writes are suppressed on any edge where reset is high, so an aborted
    // operation never disturbs the bit it was pointing at.
    assign m_ce = w_ce  & ~r;
    assign m_r  = w_clr & ~r;
    assign m_d  = w_d;
    assign m_s  = r_idx;
    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign ovf  = r_ovf;

endmodule : t64_seq
`default_nettype wire
